rotate_stream: RTL and testbench
================================

Name: rotate_stream

Overview:
- Streaming counterpart of the parallel array rotator, for the kernel-load path of the CNN datapath.
- Accepts one SIZE x SIZE matrix as a serial row-major word stream on a valid/ready writer interface and buffers it.
- Replays the matrix as a serial row-major stream of its 180-degree rotation on a valid/ready reader interface.
- Output element (r,c) = input element (SIZE-1-r, SIZE-1-c). Used to flip convolution kernels without a full parallel array bus.

Parameters:
SIZE, 7, matrix dimension (rows = cols); legal range 2..16
DATA_W, 32, element width in bits

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0, released synchronously to clk)
en  in  1  enable; gates acceptance of input words only
in_valid  in  1  input word valid
in_ready  out  1  block accepts in_data this cycle
in_data  in  DATA_W  input element, row-major order
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts out_data
out_data  out  DATA_W  rotated element, row-major order
out_row  out  $clog2(SIZE)  row index of out_data in the rotated matrix
out_col  out  $clog2(SIZE)  column index of out_data in the rotated matrix
out_last  out  1  high with the final element (index SIZE*SIZE-1)
busy  out  1  high in DRAIN, or in FILL with wr_cnt != 0

Behaviour:
- Let N = SIZE*SIZE. Storage is N x DATA_W registers, not reset.
- Counters: wr_cnt 0..N-1 and rd_cnt 0..N-1.
- States: FILL, DRAIN. State register resets to FILL.
- Reset values: in_ready=0 while reset asserted, then follows FILL rule; out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0; wr_cnt=rd_cnt=0.
- FILL:
  - in_ready = en.
  - Accept when in_valid && in_ready: mem[wr_cnt] <= in_data, wr_cnt++.
  - On accepting word N-1: wr_cnt <= 0, next state DRAIN.
  - out_valid=0.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_data = mem[N-1-rd_cnt] (combinational read of registered storage).
  - out_row = rd_cnt / SIZE, out_col = rd_cnt % SIZE, tracked by separate row/col counters; no divider.
  - out_last = (rd_cnt == N-1).
  - Handshake when out_valid && out_ready: rd_cnt++. On the handshake of N-1: rd_cnt <= 0, next state FILL.
- Latency:
  - Last input accepted at edge t -> out_valid high in the cycle after t.
  - First output word is the last input word.
  - With out_ready held high, N outputs occur on N consecutive cycles.
  - After the final output handshake, in_ready is high in the next cycle if en=1.
- Handshake rules:
  - out_data, out_row, out_col, out_last are stable while out_valid && !out_ready.
  - out_valid never drops without a handshake.
  - in_valid with in_ready=0 is ignored; no state change.
- en:
  - Affects only in_ready in FILL. en=0 mid-fill pauses with wr_cnt held.
  - en has no effect in DRAIN; the drain completes.
- Boundaries:
  - No overlap: input and output are never both active, so no simultaneous read/write of the same word.
  - wr_cnt and rd_cnt never exceed N-1.
  - Reset asserted mid-FILL or mid-DRAIN: immediate return to FILL, counters 0, partial matrix discarded, out_valid=0 asynchronously.
- Widths: counters $clog2(N) bits. Index N-1-rd_cnt is computed at counter width without underflow.

Decomposition:
- Package rotate_pkg holds:
  - state enum {FILL, DRAIN}
  - function idx_w(size) returning $clog2(size*size)
  - default SIZE/DATA_W localparams, shared with the parallel rotator
- One sub-module, rc_counter: a row/column counter with wrap at SIZE, inc and clear inputs, and row, col and last outputs. It is instantiated for the output coordinates.
- Storage and FSM stay in rotate_stream.

Test Plan:
- SIZE=7, stream in[r][c]=r+c with in_valid=1, en=1, out_ready=1 -> 49 outputs on consecutive cycles; out_data = 12-r-c at out_row=r, out_col=c; first word 12, last word 0; out_last only on word 48.
- SIZE=3, input 1..9 row-major, out_ready toggled 1,0,0,1,... -> output 9,8,...,1; out_data held stable during stalls; exactly 9 handshakes; in_ready=0 throughout the drain.
- SIZE=3, en=0 after 4 words for 5 cycles -> in_ready=0 and wr_cnt held at 4; after en=1, 5 more words are accepted and the output is the correct reverse of all 9.
- SIZE=7, reset pulsed low after 20 input words, then a fresh 49-word matrix of value 100+k -> no output before 49 new words; outputs are 148 down to 100.
- SIZE=7, reset pulsed mid-drain at output word 10 -> out_valid=0 immediately, state FILL, in_ready=1 after release.
- Back-to-back matrices A (k) then B (1000+k) -> B's first word is accepted the cycle after A's out_last handshake; B's output is 1048..1000.

Source files
------------

// File: rtl/rotate_pkg.sv
// rtl/rotate_pkg.sv - shared types and defaults for the matrix rotators
package rotate_pkg;

   localparam int SIZE_DEF   = 7;
   localparam int DATA_W_DEF = 32;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   function automatic int idx_w(input int size);
      return $clog2(size * size);
   endfunction

endpackage

// File: rtl/rc_counter.sv
// rtl/rc_counter.sv - row/column counter wrapping at SIZE, row-major order
module rc_counter
   import rotate_pkg::*;
#(
   parameter int  SIZE = SIZE_DEF,
   localparam int CW   = $clog2(SIZE)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          clear,
   output logic [CW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   localparam logic [CW-1:0] MAX = CW'(SIZE - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         if (col == MAX) begin
            col <= '0;
            row <= (row == MAX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign last = (row == MAX) && (col == MAX);

endmodule

// File: rtl/rotate_stream.sv
// rtl/rotate_stream.sv - buffers one SIZE x SIZE matrix and replays its 180-degree rotation
module rotate_stream
   import rotate_pkg::*;
#(
   parameter int  SIZE   = SIZE_DEF,
   parameter int  DATA_W = DATA_W_DEF,
   localparam int N      = SIZE * SIZE,
   localparam int IW     = idx_w(SIZE),
   localparam int CW     = $clog2(SIZE)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CW-1:0]     out_row,
   output logic [CW-1:0]     out_col,
   output logic              out_last,
   output logic              busy
);

   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t          state;
   logic [IW-1:0]   wr_cnt;
   logic [IW-1:0]   rd_cnt;
   logic [IW-1:0]   rd_idx;
   logic [DATA_W-1:0] mem [N];
   logic            in_hs;
   logic            out_hs;
   logic            rc_last;

   assign in_ready  = reset && en && (state == FILL);
   assign out_valid = (state == DRAIN);
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign busy      = (state == DRAIN) || (wr_cnt != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= FILL;
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         case (state)
            FILL: begin
               if (in_hs) begin
                  if (wr_cnt == LAST) begin
                     wr_cnt <= '0;
                     state  <= DRAIN;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (out_hs) begin
                  if (rd_cnt == LAST) begin
                     rd_cnt <= '0;
                     state  <= FILL;
                  end else begin
                     rd_cnt <= rd_cnt + 1'b1;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   // Storage is deliberately not reset; stale words are never visible outside DRAIN.
   always_ff @(posedge clk) begin
      if (in_hs) mem[wr_cnt] <= in_data;
   end

   assign rd_idx   = LAST - rd_cnt;
   assign out_data = out_valid ? mem[rd_idx] : '0;
   assign out_last = out_valid && rc_last;

   rc_counter #(.SIZE(SIZE)) u_rc (
      .clk   (clk),
      .reset (reset),
      .inc   (out_hs),
      .clear (state == FILL),
      .row   (out_row),
      .col   (out_col),
      .last  (rc_last)
   );

endmodule

// File: tb/tb_rotate_stream.sv
// tb/tb_rotate_stream.sv - scoreboard bench for rotate_stream at SIZE=7 and SIZE=3
module tb_rotate_stream;
   import rotate_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset;
   logic        en7, iv7, ir7, ov7, or7, olast7, busy7;
   logic [31:0] id7, od7;
   logic [2:0]  orow7, ocol7;
   logic        en3, iv3, ir3, ov3, or3, olast3, busy3;
   logic [31:0] id3, od3;
   logic [1:0]  orow3, ocol3;

   rotate_stream #(.SIZE(7), .DATA_W(32)) u7 (
      .clk(clk), .reset(reset), .en(en7), .in_valid(iv7), .in_ready(ir7), .in_data(id7),
      .out_valid(ov7), .out_ready(or7), .out_data(od7), .out_row(orow7), .out_col(ocol7),
      .out_last(olast7), .busy(busy7)
   );

   rotate_stream #(.SIZE(3), .DATA_W(32)) u3 (
      .clk(clk), .reset(reset), .en(en3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
      .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_row(orow3), .out_col(ocol3),
      .out_last(olast3), .busy(busy3)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Scoreboards: a full matrix of accepted words becomes its reversed expected stream.
   logic [31:0] acc7[$], exp7[$], acc3[$], exp3[$];
   int k7 = 0, h7 = 0, last_cyc7 = 0, acc_cyc7 = 0;
   int k3 = 0, h3 = 0;
   logic [31:0] held3;
   logic        stall3 = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         if (iv7 && ir7) begin
            acc7.push_back(id7);
            if (acc7.size() == 49) begin
               for (int i = 48; i >= 0; i--) exp7.push_back(acc7[i]);
               acc7.delete();
            end
         end
         if (ov7) check("d7_no_overlap", 32'(ir7), 0);
         if (ov7 && or7) begin
            if (exp7.size() == 0) check("d7_unexpected_out", 1, 0);
            else check("d7_data", od7, exp7.pop_front());
            check("d7_row", 32'(orow7), k7 / 7);
            check("d7_col", 32'(ocol7), k7 % 7);
            check("d7_last", 32'(olast7), 32'(k7 == 48));
            if (k7 == 48) begin
               last_cyc7 = cyc;
               k7 = 0;
            end else begin
               k7++;
            end
            h7++;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         if (iv3 && ir3) begin
            acc3.push_back(id3);
            if (acc3.size() == 9) begin
               for (int i = 8; i >= 0; i--) exp3.push_back(acc3[i]);
               acc3.delete();
            end
         end
         if (stall3) begin
            check("d3_valid_held", 32'(ov3), 1);
            check("d3_data_held", od3, held3);
         end
         stall3 = ov3 && !or3;
         held3  = od3;
         if (ov3) check("d3_no_overlap", 32'(ir3), 0);
         if (ov3 && or3) begin
            if (exp3.size() == 0) check("d3_unexpected_out", 1, 0);
            else check("d3_data", od3, exp3.pop_front());
            check("d3_row", 32'(orow3), k3 / 3);
            check("d3_col", 32'(ocol3), k3 % 3);
            check("d3_last", 32'(olast3), 32'(k3 == 8));
            k3 = (k3 == 8) ? 0 : k3 + 1;
            h3++;
         end
      end
   end

   // All stimulus tasks are entered and left 1 time unit after a rising edge.
   task automatic send7(input logic [31:0] v);
      int n = 0;
      iv7 = 1'b1;
      id7 = v;
      @(negedge clk);
      while (!ir7 && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!ir7) check("d7_accept_timeout", 0, 1);
      else acc_cyc7 = cyc;
      @(posedge clk);
      #1;
      iv7 = 1'b0;
   endtask

   task automatic send3(input logic [31:0] v);
      int n = 0;
      iv3 = 1'b1;
      id3 = v;
      @(negedge clk);
      while (!ir3 && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!ir3) check("d3_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      iv3 = 1'b0;
   endtask

   task automatic drain7(output int n);
      n = 0;
      while (ov7 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (ov7) check("d7_drain_timeout", 0, 1);
   endtask

   task automatic drain3();
      int n = 0;
      while (ov3 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (ov3) check("d3_drain_timeout", 0, 1);
   endtask

   task automatic pulse_reset();
      #1;
      reset = 1'b0;
      #1;
      check("rst_out_valid", 32'(ov7), 0);
      check("rst_in_ready", 32'(ir7), 0);
      check("rst_busy", 32'(busy7), 0);
      check("rst_out_data", od7, 0);
      check("rst_out_last", 32'(olast7), 0);
      check("rst_out_rowcol", {orow7, ocol7}, 0);
      check("rst_state", 32'(u7.state), 32'(FILL));
      acc7.delete(); exp7.delete(); k7 = 0;
      acc3.delete(); exp3.delete(); k3 = 0; stall3 = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      int n, h0;
      reset = 1'b0;
      en7 = 1'b1; iv7 = 1'b0; id7 = '0; or7 = 1'b1;
      en3 = 1'b1; iv3 = 1'b0; id3 = '0; or3 = 1'b1;
      @(posedge clk);
      #1;
      pulse_reset();
      @(negedge clk);
      check("post_rst_in_ready", 32'(ir7), 1);
      @(posedge clk);
      #1;

      // SIZE=7, in[r][c] = r+c, continuous flow
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 7; c++) send7(32'(r + c));
      check("t1_latency", 32'(ov7), 1);
      check("t1_first_word", od7, 12);
      h0 = h7;
      drain7(n);
      check("t1_consecutive", n, 49);
      check("t1_handshakes", h7 - h0, 49);
      check("t1_ready_after", 32'(ir7), 1);

      // SIZE=3, 1..9 with out_ready stalls
      for (int k = 1; k <= 9; k++) send3(32'(k));
      h0 = h3;
      n = 0;
      while (ov3 && n < 100) begin
         or3 = (n % 3 == 0);
         @(posedge clk);
         #1;
         n++;
      end
      or3 = 1'b1;
      check("t2_handshakes", h3 - h0, 9);
      check("t2_ready_after", 32'(ir3), 1);

      // SIZE=3, en dropped after 4 words
      for (int k = 11; k <= 14; k++) send3(32'(k));
      en3 = 1'b0;
      iv3 = 1'b1;
      id3 = 99;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_paused_ready", 32'(ir3), 0);
         check("t3_wr_cnt_held", 32'(u3.wr_cnt), 4);
         check("t3_busy", 32'(busy3), 1);
         @(posedge clk);
         #1;
      end
      iv3 = 1'b0;
      en3 = 1'b1;
      h0 = h3;
      for (int k = 15; k <= 19; k++) send3(32'(k));
      check("t3_first_word", od3, 19);
      drain3();
      check("t3_handshakes", h3 - h0, 9);

      // SIZE=7, reset after a partial fill, then a fresh matrix
      for (int k = 0; k < 20; k++) send7(32'(k));
      pulse_reset();
      for (int k = 0; k < 48; k++) send7(32'(100 + k));
      check("t4_no_early_out", 32'(ov7), 0);
      send7(148);
      check("t4_first_word", od7, 148);
      h0 = h7;
      drain7(n);
      check("t4_handshakes", h7 - h0, 49);

      // SIZE=7, reset during the drain at output word 10
      for (int k = 0; k < 49; k++) send7(32'(200 + k));
      n = 0;
      while (k7 != 10 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t5_reached_word10", k7, 10);
      check("t5_mid_drain", 32'(ov7), 1);
      pulse_reset();
      @(negedge clk);
      check("t5_ready_after", 32'(ir7), 1);
      check("t5_valid_after", 32'(ov7), 0);
      @(posedge clk);
      #1;

      // Back-to-back matrices A then B
      for (int k = 0; k < 49; k++) send7(32'(k));
      for (int k = 0; k < 49; k++) begin
         send7(32'(1000 + k));
         if (k == 0) check("t6_b_accept_gap", acc_cyc7 - last_cyc7, 1);
      end
      check("t6_first_word", od7, 1048);
      h0 = h7;
      drain7(n);
      check("t6_handshakes", h7 - h0, 49);
      check("t6_queue_empty", exp7.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
